// File: rtl/quad_enc_gen_pkg.sv
// +------------------------------------------------------------------+
// | quad_enc_gen_pkg : shared types for the quadrature step generator|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package quad_enc_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } enc_state_t;

  // Phase index of the final (AB=11) position of one detent step.
  localparam logic [2:0] PHASE_LAST = 3'd4;

endpackage

`default_nettype wire

// File: rtl/quad_phase_timer.sv
// +------------------------------------------------------------------+
// | quad_phase_timer : counts 0..TERMINAL-1 while enabled, ticks on  |
// | the last count and wraps; clear forces the count to zero.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module quad_phase_timer #(
  parameter int TERMINAL = 6000,
  parameter int W        = $clog2(TERMINAL + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    tick_o  = enable_i && (count_q == LAST);
    count_d = count_q;
    if (clear_i || tick_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/quad_enc_gen.sv
// +------------------------------------------------------------------+
// | quad_enc_gen : emulates a detented rotary encoder on A/B, playing|
// | one 4-phase Gray sequence per queued right/left step strobe.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module quad_enc_gen
  import quad_enc_gen_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int PHASE_US       = 60,
  parameter int PENDING_SIZE   = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic right_i,
  input  logic left_i,
  output logic a_o,
  output logic b_o,
  output logic busy_o,
  output logic overflow_o
);

  localparam int PW = PENDING_SIZE;
  localparam int T  = CLOCK_FREQ_MHZ * PHASE_US;

  localparam logic signed [PW:0] P1   = (PW+1)'(1);
  localparam logic signed [PW:0] M1   = -P1;
  localparam logic signed [PW:0] MAXV = (PW+1)'(2**(PW-1) - 1);
  localparam logic signed [PW:0] MINV = -MAXV;

  // Left rotation is the right sequence with A and B swapped.
  function automatic logic [1:0] gray_ab(input logic dir_right, input logic [2:0] ph);
    logic [1:0] ab;
    case (ph)
      3'd1:    ab = 2'b01;
      3'd2:    ab = 2'b00;
      3'd3:    ab = 2'b10;
      default: ab = 2'b11;
    endcase
    return dir_right ? ab : {ab[0], ab[1]};
  endfunction

  enc_state_t     state_q, state_d;
  logic           dir_q, dir_d;
  logic [2:0]     phase_q, phase_d;
  logic [1:0]     ab_q, ab_d;
  logic [PW-1:0]  pending_q, pending_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic           consume;
  logic           phase_tick;

  logic signed [PW:0] pend_ext;
  logic signed [PW:0] cons;
  logic signed [PW:0] req;
  logic signed [PW:0] base;
  logic signed [PW:0] cand;

  quad_phase_timer #(
    .TERMINAL (T)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (state_q == ST_IDLE),
    .enable_i (state_q == ST_STEP),
    .tick_o   (phase_tick)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    ab_d    = ab_q;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          consume = 1'b1;
          dir_d   = ~pending_q[PW-1];
          ab_d    = gray_ab(dir_d, 3'd1);
          phase_d = 3'd1;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (phase_tick) begin
          if (phase_q < PHASE_LAST) begin
            phase_d = phase_q + 3'd1;
            ab_d    = gray_ab(dir_q, phase_d);
          end else begin
            phase_d = 3'd0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Consumption always lands; only the new request is dropped on saturation.
  always_comb begin
    pend_ext = {pending_q[PW-1], pending_q};
    cons     = '0;
    if (consume) begin
      cons = pending_q[PW-1] ? M1 : P1;
    end
    req = '0;
    if (right_i && !left_i) begin
      req = P1;
    end else if (left_i && !right_i) begin
      req = M1;
    end
    base      = pend_ext - cons;
    cand      = base + req;
    ovf_d     = (req != '0) && ((cand > MAXV) || (cand < MINV));
    pending_d = ovf_d ? base[PW-1:0] : cand[PW-1:0];
    busy_d    = (state_d == ST_STEP) || (pending_q != '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      phase_q   <= 3'd0;
      ab_q      <= 2'b11;
      pending_q <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      ab_q      <= ab_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign a_o        = ab_q[1];
  assign b_o        = ab_q[0];
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire
